// File: rtl/fib_gen_pkg.sv
// Shared definitions for the Fibonacci-style sequence generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fib_gen_pkg;

  // Default term width and index width.
  localparam int W_DEF  = 10;
  localparam int NW_DEF = 4;

  // Controller states: IDLE (busy=0) and RUN (busy=1).
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/fib_gen_add.sv
// W-bit adder returning the modular sum and the carry out.
// Latency: combinational.
// Backpressure: none.
//   x, y : addends
//   sum  : (x + y) mod 2^W
//   co   : carry out of the W-bit add
module fib_gen_add
  import fib_gen_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] sum,
  output logic         co
);

  assign {co, sum} = {1'b0, x} + {1'b0, y};

endmodule

// File: rtl/fib_gen.sv
// Computes term T(n) of a two-seed additive sequence, modulo 2^W, with overflow flag.
// Latency: done pulses n+1 unpaused RUN cycles after the accepting edge.
// Backpressure: pause freezes all state for a cycle; abort cancels a running job.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, pause, abort: control (start taken only in IDLE with pause=0)
//   n, seed0, seed1   : job parameters, captured on accept
//   busy, done, f, overflow : status, one-cycle completion pulse, held result
module fib_gen
  import fib_gen_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int NW = NW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          pause,
  input  logic          abort,
  input  logic [NW-1:0] n,
  input  logic [W-1:0]  seed0,
  input  logic [W-1:0]  seed1,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  f,
  output logic          overflow
);

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;       // current term T(count)
  logic [W-1:0]  b_q, b_d;       // next term T(count+1)
  logic          ca_q, ca_d;     // sticky carry seen forming terms up to a
  logic          cb_q, cb_d;     // sticky carry seen forming terms up to b
  logic [NW-1:0] count_q, count_d;
  logic [NW-1:0] n_q, n_d;
  logic [W-1:0]  f_q, f_d;
  logic          ovf_q, ovf_d;
  logic          done_q, done_d;

  logic [W-1:0]  sum;
  logic          carry;

  fib_gen_add #(.W(W)) u_add (
    .x   (a_q),
    .y   (b_q),
    .sum (sum),
    .co  (carry)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    ca_d    = ca_q;
    cb_d    = cb_q;
    count_d = count_q;
    n_d     = n_q;
    f_d     = f_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    if (state_q == RUN && abort) begin
      // Abort outranks pause and completion; result registers untouched.
      state_d = IDLE;
    end else if (!pause) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            n_d     = n;
            a_d     = seed0;
            b_d     = seed1;
            ca_d    = 1'b0;
            cb_d    = 1'b0;
            count_d = '0;
            state_d = RUN;
          end
        end
        RUN: begin
          if (count_q == n_q) begin
            // a holds T(n); carries pending only in b belong to a
            // speculative term and are dropped.
            state_d = IDLE;
            done_d  = 1'b1;
            f_d     = a_q;
            ovf_d   = ca_q;
          end else begin
            a_d     = b_q;
            b_d     = sum;
            ca_d    = cb_q;
            cb_d    = cb_q | carry;
            count_d = count_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ca_q    <= 1'b0;
      cb_q    <= 1'b0;
      count_q <= '0;
      n_q     <= '0;
      f_q     <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ca_q    <= ca_d;
      cb_q    <= cb_d;
      count_q <= count_d;
      n_q     <= n_d;
      f_q     <= f_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = done_q;
  assign f        = f_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_fib_gen.sv
module tb_fib_gen;

  localparam int W  = 10;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic          abort = 1'b0;
  logic [NW-1:0] n = '0;
  logic [W-1:0]  seed0 = '0;
  logic [W-1:0]  seed1 = '0;
  logic          busy;
  logic          done;
  logic [W-1:0]  f;
  logic          overflow;

  int vectors = 0;
  int miscompares = 0;

  fib_gen #(.W(W), .NW(NW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .pause    (pause),
    .abort    (abort),
    .n        (n),
    .seed0    (seed0),
    .seed1    (seed1),
    .busy     (busy),
    .done     (done),
    .f        (f),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: build the sequence with plain integer arithmetic and flag
  // any term T(2..n) whose true sum reaches 2^W.
  task automatic model(input int s0, input int s1, input int nn,
                       output int rf, output int rov);
    int t[0:15];
    t[0] = s0;
    t[1] = s1;
    rov  = 0;
    for (int i = 2; i <= nn; i++) begin
      int s;
      s = t[i-1] + t[i-2];
      if (s >= (1 << W)) rov = 1;
      t[i] = s % (1 << W);
    end
    rf = t[nn];
  endtask

  // Accept one job, optionally pausing for plen edges starting at RUN edge
  // pat, scrambling the captured inputs meanwhile, and check the result.
  task automatic run_op(input string tag, input int s0, input int s1, input int nn,
                        input int pat, input int plen);
    int ef, eov, cycles;
    bit got;
    model(s0, s1, nn, ef, eov);
    seed0 = W'(s0);
    seed1 = W'(s1);
    n     = NW'(nn);
    start = 1'b1;
    tick();
    chk({tag, "_busy_acc"}, 32'(busy), 1);
    cycles = 0;
    got    = 1'b0;
    while (!got && cycles < 100) begin
      start = 1'($urandom);
      seed0 = W'($urandom);
      seed1 = W'($urandom);
      n     = NW'($urandom);
      pause = (cycles >= pat && cycles < pat + plen);
      tick();
      cycles++;
      if (done) got = 1'b1;
    end
    pause = 1'b0;
    start = 1'b0;
    chk({tag, "_done_seen"}, 32'(got), 1);
    chk({tag, "_latency"}, cycles, nn + 1 + plen);
    chk({tag, "_f"}, 32'(f), ef);
    chk({tag, "_ovf"}, 32'(overflow), eov);
    chk({tag, "_busy_done"}, 32'(busy), 0);
  endtask

  initial begin
    int rf, rov;
    // Reset state, before any clock edge.
    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_f", 32'(f), 0);
    chk("rst_ovf", 32'(overflow), 0);
    #11 rst_n = 1'b1;

    // Plain Fibonacci, first edge after release accepts.
    run_op("fib5", 0, 1, 5, 100, 0);
    chk("fib5_lit", 32'(f), 5);
    tick();
    chk("fib5_done_pulse", 32'(done), 0);
    chk("fib5_hold", 32'(f), 5);

    // Abort in RUN cycle 4: no done, f held.
    seed0 = 0; seed1 = 1; n = 4'd15; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    abort = 1'b1;
    pause = 1'b1;  // abort outranks pause
    tick();
    abort = 1'b0;
    pause = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_f", 32'(f), 5);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_done", 32'(done), 0);
    end

    // Lucas sequence.
    run_op("lucas4", 2, 1, 4, 100, 0);
    chk("lucas4_lit", 32'(f), 7);
    run_op("lucas0", 2, 1, 0, 100, 0);
    chk("lucas0_lit", 32'(f), 2);

    // Overflow boundary: carry on T(2) counts, speculative T(2) for n=1 does not.
    run_op("ovf2", 500, 600, 2, 100, 0);
    chk("ovf2_lit_f", 32'(f), 76);
    chk("ovf2_lit_o", 32'(overflow), 1);
    run_op("ovf1", 500, 600, 1, 100, 0);
    chk("ovf1_lit_f", 32'(f), 600);
    chk("ovf1_lit_o", 32'(overflow), 0);

    // Pause for two cycles mid-RUN.
    run_op("pause3", 0, 1, 3, 1, 2);
    chk("pause3_lit", 32'(f), 2);

    // start with pause in IDLE is not accepted.
    start = 1'b1; pause = 1'b1;
    tick();
    start = 1'b0; pause = 1'b0;
    chk("idle_pause_start", 32'(busy), 0);

    // abort+start in IDLE accepts the start.
    seed0 = 3; seed1 = 4; n = 4'd2; abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("abort_start_busy", 32'(busy), 1);
    for (int i = 0; i < 3; i++) tick();
    chk("abort_start_done", 32'(done), 1);
    chk("abort_start_f", 32'(f), 7);

    // Randomized back-to-back jobs with random pauses and input churn.
    for (int k = 0; k < 40; k++) begin
      int s0, s1, nn, pat, plen;
      s0   = int'($urandom_range(0, 1023));
      s1   = int'($urandom_range(0, 1023));
      nn   = int'($urandom_range(0, 15));
      pat  = int'($urandom_range(0, nn));
      plen = int'($urandom_range(0, 2));
      run_op("rand", s0, s1, nn, pat, plen);
    end

    // Reset mid-RUN, away from any clock edge.
    seed0 = 0; seed1 = 1; n = 4'd15; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_f", 32'(f), 0);
    chk("arst_done", 32'(done), 0);
    #2 rst_n = 1'b1;
    run_op("post_rst", 0, 1, 1, 100, 0);
    model(0, 1, 1, rf, rov);
    chk("post_rst_lit", 32'(f), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fib_gen.md
FIB_GEN -- requirements
Module: fib_gen

Interface
REQ-001 SHALL have parameter W, default 10: width of sequence terms and result.
REQ-002 SHALL have parameter NW, default 4: width of the term index n.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request a new computation.
REQ-006 SHALL have port pause  input  1  freeze the computation for the current cycle.
REQ-007 SHALL have port abort  input  1  cancel the running computation.
REQ-008 SHALL have port n  input  NW  index of the requested term.
REQ-009 SHALL have ports seed0 and seed1  input  W each  T(0) and T(1) of the sequence.
REQ-010 SHALL have port busy  output  1  computation in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-012 SHALL have port f  output  W  result T(n).
REQ-013 SHALL have port overflow  output  1  a term up to T(n) exceeded W bits.

Function
REQ-014 SHALL define T(0)=seed0, T(1)=seed1, and T(i)=T(i-1)+T(i-2) mod 2^W.
REQ-015 SHALL have two states, IDLE (busy=0) and RUN (busy=1).
REQ-016 SHALL act on an edge with pause=0 only; pause=1 holds all state, and done still clears.
REQ-017 SHALL accept start only in IDLE with pause=0; accept = capture n, seed0 and seed1, clear the step count, then enter RUN.
REQ-018 SHALL ignore changes on n, seed0 and seed1 after accept, and ignore start while in RUN.
REQ-019 SHALL complete each computation after exactly n+1 unpaused RUN cycles (n=0 -> 1 cycle).
REQ-020 On completion, SHALL return to IDLE, pulse done for one cycle, and load f=T(n) and overflow.
REQ-021 SHALL set overflow=1 iff the carry out of the W-bit add is set while forming any T(i) with 2<=i<=n; carries from speculative terms beyond T(n) SHALL NOT count.
REQ-022 SHALL hold f and overflow between completions; accept SHALL NOT change them.
REQ-023 SHALL treat abort=1 in RUN as highest priority, above pause and completion: next state IDLE, no done pulse, f and overflow unchanged.
REQ-024 SHALL ignore abort in IDLE; abort and start together in IDLE SHALL accept the start.
REQ-025 SHALL allow a new start in the cycle after done, giving back-to-back operation.
REQ-026 SHALL compute every term in W-bit modular arithmetic, with the index counter NW bits wide.

Reset
REQ-027 While rst_n=0, SHALL hold busy=0, done=0, f=0, overflow=0, state IDLE and step count 0, independent of clk.
REQ-028 Reset asserted mid-RUN SHALL discard the computation, with no done pulse.
REQ-029 After rst_n rises, the first rising edge of clk SHALL be able to accept a start.

Structure
REQ-030 Shared package fib_gen_pkg SHALL hold the state enum (IDLE, RUN) and the default W and NW constants.
REQ-031 Sub-module fib_gen_add SHALL be a W-bit adder returning the sum and the carry out; it is the only arithmetic instance.
REQ-032 Datapath registers SHALL be: a (current term), b (next term), count (NW bits), and one pending-carry bit per held term.

Verification (W=10, NW=4)
REQ-033 seeds 0/1, n=5, start for 1 cycle, pause=0 -> done 6 cycles after accept; f=5; overflow=0.
REQ-034 seeds 2/1 (Lucas), n=4 -> f=7; n=0 -> f=2 with done 1 cycle after accept.
REQ-035 seeds 500/600, n=2 -> f=76, overflow=1; same seeds with n=1 -> f=600, overflow=0.
REQ-036 seeds 0/1, n=3, pause high for 2 cycles mid-RUN -> done 6 cycles after accept; f=2.
REQ-037 after f=5, start seeds 0/1, n=15, abort at RUN cycle 4 -> busy=0 next cycle; no done; f stays 5.
REQ-038 rst_n low mid-RUN with no clk edge -> busy=0 and f=0 immediately; start n=1 after release -> f=1.
